// File: rtl/pe_ctrl_pkg.sv
// Shared types and lane helpers for the PE block sequencer.
package pe_ctrl_pkg;

    localparam int unsigned PE_ROWS = 8;
    localparam int unsigned PE_COLS = 4;
    localparam int unsigned IFMAP_W = 8;
    localparam int unsigned PSUM_W  = 32;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFire,
        StWait,
        StOut
    } pe_state_e;

    // Extract weight lane r from a packed weight vector.
    function automatic logic [IFMAP_W-1:0] weight_lane(
        input logic [PE_ROWS*IFMAP_W-1:0] v,
        input int unsigned                r
    );
        return v[r*IFMAP_W +: IFMAP_W];
    endfunction

    // Extract partial-sum lane r from a packed psum vector.
    function automatic logic [PSUM_W-1:0] psum_lane(
        input logic [PE_ROWS*PSUM_W-1:0] v,
        input int unsigned               r
    );
        return v[r*PSUM_W +: PSUM_W];
    endfunction

    // Return v with partial-sum lane r replaced by x.
    function automatic logic [PE_ROWS*PSUM_W-1:0] psum_set_lane(
        input logic [PE_ROWS*PSUM_W-1:0] v,
        input int unsigned               r,
        input logic [PSUM_W-1:0]         x
    );
        logic [PE_ROWS*PSUM_W-1:0] t;
        t = v;
        t[r*PSUM_W +: PSUM_W] = x;
        return t;
    endfunction

endpackage

// File: rtl/pe_ctrl_out_reg.sv
// Partial-sum register bank plus the valid/ready result holding stage.
module pe_ctrl_out_reg
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ROWS = PE_ROWS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   last,
    input  logic [ROWS*PSUM_W-1:0] load_data,
    input  logic                   out_ready,
    output logic [ROWS*PSUM_W-1:0] psum,
    output logic                   out_valid,
    output logic [ROWS*PSUM_W-1:0] out_data,
    output logic                   out_fire
);

    logic [ROWS*PSUM_W-1:0] psum_q;
    logic                   valid_q;

    // Capture each pass result; raise valid after the last pass until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (load) begin
                psum_q <= load_data;
            end
            if (load && last) begin
                valid_q <= 1'b1;
            end else if (valid_q && out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign psum      = psum_q;
    assign out_valid = valid_q;
    assign out_data  = valid_q ? psum_q : '0;
    assign out_fire  = valid_q & out_ready;

endmodule

// File: rtl/pe_block_ctrl.sv
// Pass sequencer for one int8 PE block: fetch, fire, wait, accumulate, present.
module pe_block_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ROWS    = PE_ROWS,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned PASS_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [PASS_W-1:0]       cfg_num_pass,
    input  logic [ADDR_W-1:0]       cfg_ifmap_base,
    input  logic [ADDR_W-1:0]       cfg_weight_base,
    input  logic [ADDR_W-1:0]       cfg_bias_base,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    ifmap_rd_en,
    output logic [ADDR_W-1:0]       ifmap_rd_addr,
    input  logic [IFMAP_W-1:0]      ifmap_rd_data,
    output logic                    weight_rd_en,
    output logic [ADDR_W-1:0]       weight_rd_addr,
    input  logic [ROWS*IFMAP_W-1:0] weight_rd_data,
    output logic                    bias_rd_en,
    output logic [ADDR_W-1:0]       bias_rd_addr,
    input  logic [ROWS*PSUM_W-1:0]  bias_rd_data,
    output logic                    pe_en,
    output logic [IFMAP_W-1:0]      pe_ifmap,
    output logic [ROWS*IFMAP_W-1:0] pe_weight,
    output logic [ROWS*PSUM_W-1:0]  pe_bias,
    input  logic [ROWS*PSUM_W-1:0]  pe_ofmap,
    input  logic                    pe_valid,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ROWS*PSUM_W-1:0]  out_data
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);

    pe_state_e              state_q;
    logic [PASS_W-1:0]      pass_q;
    logic [PASS_W-1:0]      num_pass_q;
    logic [ADDR_W-1:0]      ifmap_base_q;
    logic [ADDR_W-1:0]      weight_base_q;
    logic [TIMER_W-1:0]     timer_q;

    logic [PASS_W-1:0]      pass_nxt;
    logic [ADDR_W-1:0]      pass_off;
    logic                   last_pass;
    logic                   psum_load;
    logic                   out_fire;
    logic [ROWS*PSUM_W-1:0] psum;

    assign pass_nxt  = pass_q + PASS_W'(1);
    // Address offset wraps with the buffer address space.
    assign pass_off  = ADDR_W'(pass_nxt);
    assign last_pass = (pass_nxt == num_pass_q);
    assign psum_load = (state_q == StWait) && pe_valid;

    // PE inputs are only driven during the single FIRE cycle; the first pass
    // takes its bias from the buffer, later passes from the running psums.
    assign pe_ifmap  = (state_q == StFire) ? ifmap_rd_data : '0;
    assign pe_weight = (state_q == StFire) ? weight_rd_data : '0;
    assign pe_bias   = (state_q != StFire) ? '0 :
                       (pass_q == '0)      ? bias_rd_data : psum;

    // Main FSM with pass counter, watchdog and registered control outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            pass_q         <= '0;
            num_pass_q     <= '0;
            ifmap_base_q   <= '0;
            weight_base_q  <= '0;
            timer_q        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            ifmap_rd_en    <= 1'b0;
            ifmap_rd_addr  <= '0;
            weight_rd_en   <= 1'b0;
            weight_rd_addr <= '0;
            bias_rd_en     <= 1'b0;
            bias_rd_addr   <= '0;
            pe_en          <= 1'b0;
        end else begin
            done         <= 1'b0;
            ifmap_rd_en  <= 1'b0;
            weight_rd_en <= 1'b0;
            bias_rd_en   <= 1'b0;
            pe_en        <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        err <= 1'b0;
                        if (cfg_num_pass != '0) begin
                            num_pass_q     <= cfg_num_pass;
                            ifmap_base_q   <= cfg_ifmap_base;
                            weight_base_q  <= cfg_weight_base;
                            pass_q         <= '0;
                            busy           <= 1'b1;
                            state_q        <= StLoad;
                            ifmap_rd_en    <= 1'b1;
                            ifmap_rd_addr  <= cfg_ifmap_base;
                            weight_rd_en   <= 1'b1;
                            weight_rd_addr <= cfg_weight_base;
                            bias_rd_en     <= 1'b1;
                            bias_rd_addr   <= cfg_bias_base;
                        end else begin
                            // Empty job: acknowledge without touching buffers.
                            done <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    pe_en   <= 1'b1;
                    state_q <= StFire;
                end
                StFire: begin
                    timer_q <= '0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (pe_valid) begin
                        pass_q <= pass_nxt;
                        if (last_pass) begin
                            state_q <= StOut;
                        end else begin
                            state_q        <= StLoad;
                            ifmap_rd_en    <= 1'b1;
                            ifmap_rd_addr  <= ifmap_base_q + pass_off;
                            weight_rd_en   <= 1'b1;
                            weight_rd_addr <= weight_base_q + pass_off;
                        end
                    end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
                        err     <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        timer_q <= timer_q + TIMER_W'(1);
                    end
                end
                StOut: begin
                    if (out_fire) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    pe_ctrl_out_reg #(
        .ROWS (ROWS)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (psum_load),
        .last      (last_pass),
        .load_data (pe_ofmap),
        .out_ready (out_ready),
        .psum      (psum),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_fire  (out_fire)
    );

endmodule

// File: tb/tb_pe_block_ctrl.sv
// Directed bench for pe_block_ctrl with buffer and PE block models.
module tb_pe_block_ctrl;
    import pe_ctrl_pkg::*;

    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  cfg_num_pass;
    logic [9:0]   cfg_ifmap_base, cfg_weight_base, cfg_bias_base;
    logic         busy, done, err;
    logic         ifmap_rd_en, weight_rd_en, bias_rd_en;
    logic [9:0]   ifmap_rd_addr, weight_rd_addr, bias_rd_addr;
    logic [7:0]   ifmap_rd_data;
    logic [63:0]  weight_rd_data;
    logic [255:0] bias_rd_data;
    logic         pe_en, pe_valid;
    logic [7:0]   pe_ifmap;
    logic [63:0]  pe_weight;
    logic [255:0] pe_bias, pe_ofmap;
    logic         out_valid, out_ready;
    logic [255:0] out_data;

    pe_block_ctrl #(
        .ROWS    (8),
        .ADDR_W  (10),
        .PASS_W  (16),
        .TIMEOUT (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .cfg_num_pass    (cfg_num_pass),
        .cfg_ifmap_base  (cfg_ifmap_base),
        .cfg_weight_base (cfg_weight_base),
        .cfg_bias_base   (cfg_bias_base),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .ifmap_rd_en     (ifmap_rd_en),
        .ifmap_rd_addr   (ifmap_rd_addr),
        .ifmap_rd_data   (ifmap_rd_data),
        .weight_rd_en    (weight_rd_en),
        .weight_rd_addr  (weight_rd_addr),
        .weight_rd_data  (weight_rd_data),
        .bias_rd_en      (bias_rd_en),
        .bias_rd_addr    (bias_rd_addr),
        .bias_rd_data    (bias_rd_data),
        .pe_en           (pe_en),
        .pe_ifmap        (pe_ifmap),
        .pe_weight       (pe_weight),
        .pe_bias         (pe_bias),
        .pe_ofmap        (pe_ofmap),
        .pe_valid        (pe_valid),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data)
    );

    always #5 clk = ~clk;

    // Buffer models: one-cycle read latency.
    logic [7:0]   ifmap_mem  [0:1023];
    logic [63:0]  weight_mem [0:1023];
    logic [255:0] bias_mem   [0:1023];

    always @(posedge clk) begin
        if (ifmap_rd_en)  ifmap_rd_data  <= ifmap_mem[ifmap_rd_addr];
        if (weight_rd_en) weight_rd_data <= weight_mem[weight_rd_addr];
        if (bias_rd_en)   bias_rd_data   <= bias_mem[bias_rd_addr];
    end

    // PE block model: ofmap[r] = bias[r] + 4*ifmap*weight[r], valid pe_lat cycles after pe_en.
    int           pe_lat  = 4;
    logic         pe_mute = 1'b0;
    int           pe_cnt;
    logic [255:0] pe_res;

    function automatic logic [255:0] pe_calc(input logic [7:0] x, input logic [63:0] w,
                                             input logic [255:0] b);
        logic [255:0] r;
        int xs, ws, bs;
        r  = '0;
        xs = $signed(x);
        for (int i = 0; i < 8; i++) begin
            ws = $signed(weight_lane(w, i));
            bs = $signed(psum_lane(b, i));
            r  = psum_set_lane(r, i, 32'(bs + 4 * xs * ws));
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pe_cnt <= 0;
            pe_res <= '0;
        end else if (pe_en) begin
            pe_cnt <= pe_lat;
            pe_res <= pe_calc(pe_ifmap, pe_weight, pe_bias);
        end else if (pe_cnt != 0) begin
            pe_cnt <= pe_cnt - 1;
        end
    end

    assign pe_valid = (pe_cnt == 1) && !pe_mute;
    assign pe_ofmap = pe_res;

    // Activity monitors, sampled at the clock edge.
    int       bias_cnt = 0, rd_cnt = 0, busy_cnt = 0, done_cnt = 0;
    logic [9:0] rd_log [0:255];

    always @(posedge clk) begin
        if (bias_rd_en) bias_cnt++;
        if (ifmap_rd_en) begin
            rd_log[rd_cnt % 256] = ifmap_rd_addr;
            rd_cnt++;
        end
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    logic [37:0] ctl;
    assign ctl = {busy, done, err, ifmap_rd_en, weight_rd_en, bias_rd_en, pe_en, out_valid,
                  ifmap_rd_addr, weight_rd_addr, bias_rd_addr};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Job vector: pass k reads ifmap x0+k, all weight lanes w, bias lane r = b + bs*r.
    typedef struct {
        int n; int ifb; int wb; int bb; int x0; int w; int b; int bs; int lat;
        int e0; int e7; int alast; int cyc;
    } vec_t;

    vec_t vecs [4];

    task automatic fill_mem(input vec_t v);
        logic [7:0]   w8;
        logic [255:0] bv;
        w8 = 8'(v.w);
        bv = '0;
        for (int k = 0; k < v.n; k++) begin
            ifmap_mem[(v.ifb + k) % 1024]  = 8'(v.x0 + k);
            weight_mem[(v.wb + k) % 1024] = {8{w8}};
        end
        for (int r = 0; r < 8; r++) bv = psum_set_lane(bv, r, 32'(v.b + v.bs * r));
        bias_mem[v.bb] = bv;
    endtask

    task automatic set_cfg(input vec_t v);
        cfg_num_pass    = 16'(v.n);
        cfg_ifmap_base  = 10'(v.ifb);
        cfg_weight_base = 10'(v.wb);
        cfg_bias_base   = 10'(v.bb);
    endtask

    task automatic run_job(input vec_t v, input int hold);
        int           cyc, b0, r0;
        logic [255:0] snap;
        fill_mem(v);
        pe_lat    = v.lat;
        b0        = bias_cnt;
        r0        = rd_cnt;
        out_ready = (hold == 0);
        set_cfg(v);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
        while (!out_valid && cyc < 2000) begin
            step();
            cyc++;
        end
        chk("latency", 256'(cyc), 256'(v.cyc));
        chk("lane0", 256'(psum_lane(out_data, 0)), 256'(32'(v.e0)));
        chk("lane7", 256'(psum_lane(out_data, 7)), 256'(32'(v.e7)));
        chk("bias_reads", 256'(bias_cnt - b0), 256'(1));
        chk("ifmap_reads", 256'(rd_cnt - r0), 256'(v.n));
        chk("addr_first", 256'(rd_log[r0 % 256]), 256'(v.ifb));
        chk("addr_last", 256'(rd_log[(r0 + v.n - 1) % 256]), 256'(v.alast));
        chk("done_in_out", 256'(done), 256'(0));
        snap = out_data;
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 256'(out_valid), 256'(1));
            chk("hold_data", out_data, snap);
            chk("hold_done", 256'(done), 256'(0));
            cfg_num_pass = 16'd0;
            start        = 1'b1;
            step();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("done_pulse", 256'({done, out_valid, busy}), 256'(3'b100));
        step();
        chk("done_low", 256'({done, busy}), 256'(2'b00));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc, b0, r0, d0;
        logic ov_seen;

        //           n  ifb   wb   bb   x0  w   b    bs  lat e0   e7   alast cyc
        vecs[0] = '{1, 0,    0,   0,   3,  2,  0,   1,  4,  24,  31,  0,    6};
        vecs[1] = '{3, 100,  200, 300, 1,  1,  10,  0,  4,  34,  34,  102,  18};
        vecs[2] = '{2, 500,  7,   9,   -5, -3, 100, -2, 1,  208, 194, 501,  6};
        vecs[3] = '{2, 1023, 1022, 5,  7,  1,  0,   0,  2,  60,  60,  0,    8};

        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        set_cfg(vecs[0]);
        repeat (2) step();
        chk("reset_ctl", 256'(ctl), 256'(0));
        chk("reset_pe_bias", pe_bias, 256'(0));
        chk("reset_out_data", out_data, 256'(0));
        chk("reset_pe_in", 256'({pe_ifmap, pe_weight}), 256'(0));
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_job(vecs[i], 0);

        // Backpressure with ignored start requests during OUT.
        run_job(vecs[0], 5);

        // Zero-length job.
        b0 = busy_cnt;
        r0 = rd_cnt;
        cfg_num_pass = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_done", 256'(done), 256'(1));
        step();
        chk("zero_done_low", 256'(done), 256'(0));
        chk("zero_busy", 256'(busy_cnt - b0), 256'(0));
        chk("zero_reads", 256'(rd_cnt - r0), 256'(0));

        // Watchdog abort when the PE never answers.
        fill_mem(vecs[0]);
        pe_lat  = 4;
        pe_mute = 1'b1;
        set_cfg(vecs[0]);
        start = 1'b1;
        step();
        start   = 1'b0;
        cyc     = 0;
        ov_seen = 1'b0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
            if (out_valid) ov_seen = 1'b1;
        end
        chk("timeout_cycles", 256'(cyc), 256'(TO + 2));
        chk("timeout_err", 256'({err, busy}), 256'(2'b10));
        chk("timeout_no_out", 256'(ov_seen), 256'(0));
        step();
        chk("err_sticky", 256'({err, done}), 256'(2'b10));
        pe_mute      = 1'b0;
        cfg_num_pass = 16'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("err_cleared", 256'({err, done}), 256'(2'b01));
        step();

        // Reset in the middle of WAIT.
        fill_mem(vecs[1]);
        pe_lat = 4;
        set_cfg(vecs[1]);
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("busy_in_wait", 256'(busy), 256'(1));
        rst = 1'b1;
        #1;
        chk("midrst_ctl", 256'(ctl), 256'(0));
        chk("midrst_pe_bias", pe_bias, 256'(0));
        chk("midrst_out", out_data, 256'(0));
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("midrst_no_done", 256'(done_cnt - d0), 256'(0));
        run_job(vecs[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
